// File: rtl/rtc_match_int_gen.sv
// rtc_match_int_gen: RTC counter, match register and mask, with the raw/masked match interrupt.
//   PCLK       - sole clock
//   PRESETn    - asynchronous active-low reset
//   CountEn    - one-cycle increment tick (already synchronised)
//   LoadWr     - write strobe for the counter; LoadData is the new counter value
//   MatchWr    - write strobe for the match register; MatchData is the new match value
//   MaskWr     - write strobe for the interrupt mask; MaskData is the new mask (1 = enabled)
//   IntClear   - clear request returned by the interrupt-clear block
//   RtcCount   - current counter value
//   RtcMatch   - current match value
//   IntMask    - current mask bit
//   RawInt     - raw match interrupt, held until cleared
//   MaskedInt  - RawInt AND IntMask
module rtc_match_int_gen #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 CountEn,
    input  logic                 LoadWr,
    input  logic [CNT_WIDTH-1:0] LoadData,
    input  logic                 MatchWr,
    input  logic [CNT_WIDTH-1:0] MatchData,
    input  logic                 MaskWr,
    input  logic                 MaskData,
    input  logic                 IntClear,
    output logic [CNT_WIDTH-1:0] RtcCount,
    output logic [CNT_WIDTH-1:0] RtcMatch,
    output logic                 IntMask,
    output logic                 RawInt,
    output logic                 MaskedInt
);
    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d, match_q, match_d;
    logic                 mask_q, mask_d, equal_q, equal_d;
    logic                 equal, match_evt;
    assign equal     = (count_q == match_q);
    // Only a rising edge of equality is an event, so a held match fires once.
    assign match_evt = equal && !equal_q;
    always_comb begin
        count_d = LoadWr ? LoadData : CountEn ? count_q + 1'b1 : count_q;
        match_d = MatchWr ? MatchData : match_q;
        mask_d  = MaskWr ? MaskData : mask_q;
        equal_d = equal;
        state_d = state_q;
        case (state_q)
            IDLE: state_d = match_evt ? PEND : IDLE;
            PEND: state_d = (IntClear && !match_evt) ? IDLE : PEND;
            default: state_d = IDLE;
        endcase
    end
    // equal_q resets to 1 because count and match both reset to 0; this
    // suppresses a false event on reset release.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            count_q <= '0;
            match_q <= '0;
            mask_q  <= 1'b0;
            equal_q <= 1'b1;
            state_q <= IDLE;
        end else begin
            count_q <= count_d;
            match_q <= match_d;
            mask_q  <= mask_d;
            equal_q <= equal_d;
            state_q <= state_d;
        end
    end
    assign RtcCount  = count_q;
    assign RtcMatch  = match_q;
    assign IntMask   = mask_q;
    assign RawInt    = (state_q == PEND);
    assign MaskedInt = RawInt && mask_q;
endmodule
